actuated_signal_scheduler: RTL and testbench
============================================

# actuated_signal_scheduler

Demand-actuated scheduler for a 4-approach intersection. It arbitrates green time among vehicle-detector requests with round-robin fairness, enforces minimum and maximum green, yellow and all-red clearance, and supports an emergency-vehicle preempt. It drives the per-approach light codes on the `uo_out` lanes, replacing the fixed-cycle sequencer.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per timing tick (1 s at 50 MHz).
- `MIN_GREEN`, default 5: minimum green, in ticks (≥1).
- `MAX_GREEN`, default 15: maximum green under contention, in ticks (≥ `MIN_GREEN`).
- `YELLOW_T`, default 1: yellow duration, in ticks (≥1).
- `ALLRED_T`, default 1: all-red clearance, in ticks (≥1).
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in 4: level vehicle-present detectors; bit 0=N, 1=E, 2=S, 3=W.
- `emg_valid` in 1: emergency preempt request, level.
- `emg_dir` in 2: approach index the emergency vehicle arrives on.
- `lights` out 8: {N[7:6], E[5:4], S[3:2], W[1:0]}; red=00, yellow=01, green=10; 11 never driven.
- `active_dir` out 2: approach currently served (green or yellow); holds the last served approach otherwise.
- `busy` out 1: high in GREEN or YELLOW.

## Operation
- States: ALLRED, IDLE, GREEN, YELLOW. Lights decode from the registered state and `active_dir` only (Moore):
  - GREEN: served approach = 10, others 00.
  - YELLOW: served approach = 01, others 00.
  - ALLRED and IDLE: all 00.
- Reset values: state=ALLRED, `active_dir`=3 (so N wins the first arbitration), elapsed=0, divider=0, `lights`=8'h00, `busy`=0.
- Tick: divider counts 0..`TICK_DIV`-1 and pulses `tick` on the wrap. Divider and `elapsed` clear on every state change. `elapsed` saturates at `MAX_GREEN`.
- Arbitration (ALLRED exit and IDLE):
  - If `emg_valid`, select `emg_dir`.
  - Otherwise select the first set `req` bit, scanning upward from `active_dir`+1 (mod 4).
- ALLRED: hold until `elapsed`==`ALLRED_T`. Then go to GREEN on the arbitrated approach if any request or emergency exists, else go to IDLE.
- IDLE: all red. On the first cycle with any `req` or `emg_valid`, go to GREEN on the arbitrated approach at the next edge.
- GREEN on approach d:
  - `others` = `req` with bit d masked off, OR (`emg_valid` and `emg_dir`≠d).
  - If `emg_valid` and `emg_dir`≠d, go to YELLOW immediately, ignoring min green.
  - If `emg_valid` and `emg_dir`==d, hold green with no max limit.
  - Otherwise, when `elapsed`≥`MIN_GREEN` and `others`≠0 and (`req[d]`==0 or `elapsed`==`MAX_GREEN`), go to YELLOW.
  - With `others`==0, rest in green indefinitely.
- YELLOW: hold until `elapsed`==`YELLOW_T`, then go to ALLRED. Preempt never shortens yellow or all-red.
- Requests are sampled every cycle and are not latched. A request that drops before service is forgotten.

## Timing
- Transitions are registered. A condition true on cycle c changes `lights` on edge c+1.
- From entry, a phase of N ticks lasts exactly N·`TICK_DIV` cycles: `elapsed` reaches N on the Nth tick and the exit is taken on that same edge.
- IDLE→GREEN latency: 1 cycle after the request is first seen high.
- Emergency from a conflicting GREEN: YELLOW 1 cycle after `emg_valid` rises. Emergency green is reached after (1 + (`YELLOW_T`+`ALLRED_T`)·`TICK_DIV`) cycles.
- Simultaneous events:
  - Emergency outranks round-robin.
  - A request on d arriving the same cycle d's green would end keeps d green only if `elapsed`<`MAX_GREEN`.
  - `emg_dir` changing mid-preempt is re-evaluated each cycle by the same rules.
- `reset` asserted mid-phase: `lights` go to all red asynchronously, and the full `ALLRED_T` clearance runs after release.

## Structure
- Package `signal_pkg`: light codes (RED, YELLOW, GREEN), state enum, direction indices N/E/S/W=0..3.
- Sub-module `sig_tick_gen`: divider with synchronous clear input, `tick` output, parameter `TICK_DIV`.
- Round-robin picker: a function inside the scheduler, not a separate module.

## Test plan
All scenarios use `TICK_DIV`=4, `MIN_GREEN`=2, `MAX_GREEN`=4, `YELLOW_T`=1, `ALLRED_T`=1.
- Reset, no requests: `lights`=00 throughout; IDLE reached at cycle 4.
- `req`=0001 held from cycle 10: `lights`=8'h80 at cycle 11 and held indefinitely; `busy`=1.
- N green, E requests at N-green `elapsed`=0, N `req` held: N stays green 16 cycles (MAX), then yellow (8'h40) for 4 cycles, then all red for 4 cycles, then E green (8'h20).
- `req`=1111 continuously: grant order N,E,S,W,N; each green is 16 cycles.
- S green at `elapsed`=0, `emg_valid`=1, `emg_dir`=W: S yellow next cycle, all red after 4 cycles, W green (8'h02) after 4 more.
- `reset` pulse during E green: `lights`=00 immediately; after release, N gets first green if `req[0]`=1.

Source files
------------

// File: rtl/signal_pkg.sv
// Shared light codes, scheduler states and approach indices for the
// actuated signal scheduler.
package signal_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_e;

  // Lane packing is {N, E, S, W} from the top, so approach i sits at bits [7-2i:6-2i].
  function automatic logic [7:0] light_decode(state_e st, logic [1:0] dir);
    logic [1:0] code;
    logic [7:0] lanes;
    case (st)
      ST_GREEN:  code = GREEN;
      ST_YELLOW: code = YELLOW;
      default:   code = RED;
    endcase
    lanes = 8'h00;
    for (int i = 0; i < 4; i++) begin
      lanes[6-2*i +: 2] = (2'(i) == dir) ? code : RED;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/actuated_signal_scheduler_if.sv
// Detector/preempt inputs and light outputs of the scheduler, bundled as one bus.
interface actuated_signal_scheduler_if;
  import signal_pkg::*;

  logic [3:0] req;
  logic       emg_valid;
  logic [1:0] emg_dir;
  logic [7:0] lights;
  logic [1:0] active_dir;
  logic       busy;

  modport master (
    output req, emg_valid, emg_dir,
    input  lights, active_dir, busy
  );

  modport slave (
    input  req, emg_valid, emg_dir,
    output lights, active_dir, busy
  );

endinterface

// File: rtl/sig_tick_gen.sv
// Timing-tick divider: counts 0..TICK_DIV-1, pulses tick on the wrap, and
// restarts from zero whenever clr is asserted.
module sig_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/actuated_signal_scheduler.sv
// Demand-actuated four-approach scheduler: round-robin green allocation with
// min/max green, yellow and all-red clearance, and emergency preempt.
module actuated_signal_scheduler
  import signal_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW_T  = 1,
  parameter int ALLRED_T  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  actuated_signal_scheduler_if.slave  bus
);

  localparam int EW = $clog2(MAX_GREEN + 1);
  localparam logic [EW-1:0] MIN_E = EW'(MIN_GREEN);
  localparam logic [EW-1:0] MAX_E = EW'(MAX_GREEN);
  localparam logic [EW-1:0] YEL_E = EW'(YELLOW_T);
  localparam logic [EW-1:0] AR_E  = EW'(ALLRED_T);

  // First set request strictly after `last`, wrapping; `last` itself is checked last.
  function automatic logic [1:0] rr_pick(logic [3:0] r, logic [1:0] last);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx   = last + 2'(i);
      sel   = (!found && r[idx]) ? idx : sel;
      found = found | r[idx];
    end
    return sel;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic [7:0]    lights_q, lights_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          state_chg;
  logic [EW-1:0] el_eff;
  logic [1:0]    pick;
  logic          any_dem;
  logic [3:0]    others;
  logic          emg_conflict;

  sig_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  // Phase decisions use the count including this cycle's tick, so an N-tick
  // phase exits on the same edge its Nth tick lands.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    el_eff       = (tick && (elapsed_q != MAX_E)) ? elapsed_q + EW'(1) : elapsed_q;
    pick         = bus.emg_valid ? bus.emg_dir : rr_pick(bus.req, dir_q);
    any_dem      = (bus.req != 4'b0000) || bus.emg_valid;
    emg_conflict = bus.emg_valid && (bus.emg_dir != dir_q);
    others       = bus.req & ~(4'b0001 << dir_q);

    case (state_q)
      ST_ALLRED: begin
        if (el_eff == AR_E) begin
          if (any_dem) begin
            state_d = ST_GREEN;
            dir_d   = pick;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ALLRED;
        end
      end
      ST_IDLE: begin
        if (any_dem) begin
          state_d = ST_GREEN;
          dir_d   = pick;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GREEN: begin
        if (emg_conflict) begin
          state_d = ST_YELLOW;
        end else if (bus.emg_valid) begin
          state_d = ST_GREEN;
        end else if ((others != 4'b0000) && (el_eff >= MIN_E) &&
                     (!bus.req[dir_q] || (el_eff == MAX_E))) begin
          state_d = ST_YELLOW;
        end else begin
          state_d = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (el_eff == YEL_E) begin
          state_d = ST_ALLRED;
        end else begin
          state_d = ST_YELLOW;
        end
      end
      default: begin
        state_d = ST_ALLRED;
      end
    endcase

    state_chg = (state_d != state_q);
    elapsed_d = state_chg ? '0 : el_eff;
    lights_d  = light_decode(state_d, dir_d);
    busy_d    = (state_d == ST_GREEN) || (state_d == ST_YELLOW);
  end

  // Lights and busy are registered from the next state so they change on the
  // same edge as the phase itself and clear asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ALLRED;
      dir_q     <= DIR_W;
      elapsed_q <= '0;
      lights_q  <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      elapsed_q <= elapsed_d;
      lights_q  <= lights_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.lights     = lights_q;
  assign bus.active_dir = dir_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_actuated_signal_scheduler.sv
// Scoreboard bench: the driver advances a cycle-counting reference model and
// queues the expected outputs; the monitor pops and compares after each edge.
module tb_actuated_signal_scheduler;

  localparam int TD   = 4;
  localparam int MING = 2;
  localparam int MAXG = 4;
  localparam int YT   = 1;
  localparam int AR   = 1;

  localparam int P_ALLRED = 0;
  localparam int P_IDLE   = 1;
  localparam int P_GREEN  = 2;
  localparam int P_YELLOW = 3;

  logic clk;
  logic reset;
  actuated_signal_scheduler_if bus ();

  actuated_signal_scheduler #(
    .TICK_DIV (TD),
    .MIN_GREEN(MING),
    .MAX_GREEN(MAXG),
    .YELLOW_T (YT),
    .ALLRED_T (AR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [10:0] exp_q[$];

  int m_phase;
  int m_dir;
  int m_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] model_outputs(int phase, int dir);
    logic [7:0] l;
    logic [1:0] code;
    l = 8'h00;
    code = (phase == P_GREEN) ? 2'b10 : (phase == P_YELLOW) ? 2'b01 : 2'b00;
    l[6-2*dir +: 2] = code;
    return {l, 2'(dir), (phase == P_GREEN || phase == P_YELLOW)};
  endfunction

  task automatic model_reset();
    m_phase = P_ALLRED;
    m_dir   = 3;
    m_n     = 0;
  endtask

  // One cycle of the reference model: ticks are whole TD-cycle blocks since entry.
  task automatic model_step(input logic [3:0] r, input logic ev, input logic [1:0] ed);
    int  t, pick, nxt, ndir;
    bit  any, found;
    logic [3:0] oth;
    any = (r != 4'b0000) || ev;
    pick = m_dir;
    found = 0;
    if (ev) pick = ed;
    else begin
      for (int k = 1; k <= 4; k++) begin
        if (!found && r[(m_dir + k) % 4]) begin
          pick = (m_dir + k) % 4;
          found = 1;
        end
      end
    end
    m_n = m_n + 1;
    t = m_n / TD;
    if (t > MAXG) t = MAXG;
    nxt = m_phase;
    ndir = m_dir;
    case (m_phase)
      P_ALLRED: if (t == AR) begin
        if (any) begin nxt = P_GREEN; ndir = pick; end
        else nxt = P_IDLE;
      end
      P_IDLE: if (any) begin nxt = P_GREEN; ndir = pick; end
      P_GREEN: begin
        oth = r;
        oth[m_dir] = 1'b0;
        if (ev && ed != 2'(m_dir)) nxt = P_YELLOW;
        else if (ev) nxt = P_GREEN;
        else if (oth != 4'b0000 && t >= MING && (!r[m_dir] || t == MAXG)) nxt = P_YELLOW;
      end
      P_YELLOW: if (t == YT) nxt = P_ALLRED;
      default: nxt = P_ALLRED;
    endcase
    if (nxt != m_phase) m_n = 0;
    m_phase = nxt;
    m_dir   = ndir;
  endtask

  task automatic drive_cycle(input logic rst, input logic [3:0] r, input logic ev,
                             input logic [1:0] ed);
    @(negedge clk);
    reset         = rst;
    bus.req       = r;
    bus.emg_valid = ev;
    bus.emg_dir   = ed;
    if (rst) model_reset();
    else model_step(r, ev, ed);
    exp_q.push_back(model_outputs(m_phase, m_dir));
  endtask

  task automatic check_now(input string name, input logic [10:0] want);
    logic [10:0] got;
    got = {bus.lights, bus.active_dir, bus.busy};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got lights=%h dir=%0d busy=%0b, expected lights=%h dir=%0d busy=%0b",
               name, got[10:3], got[2:1], got[0], want[10:3], want[2:1], want[0]);
    end
  endtask

  // Monitor: every registered output update is compared against the queue head.
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now($sformatf("outputs@%0d", cyc), e);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       ev;
    logic [1:0] ed;
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.emg_valid = 1'b0;
    bus.emg_dir = 2'd0;
    model_reset();
    #7;
    check_now("reset_state", 11'b00000000_11_0);
    repeat (3) drive_cycle(1'b1, 4'b0000, 1'b0, 2'd0);

    repeat (10) drive_cycle(1'b0, 4'b0000, 1'b0, 2'd0);
    repeat (30) drive_cycle(1'b0, 4'b0001, 1'b0, 2'd0);
    repeat (20) drive_cycle(1'b0, 4'b0000, 1'b0, 2'd0);
    repeat (40) drive_cycle(1'b0, 4'b0010, 1'b0, 2'd0);
    repeat (90) drive_cycle(1'b0, 4'b1111, 1'b0, 2'd0);
    repeat (30) drive_cycle(1'b0, 4'b1111, 1'b1, 2'd3);
    repeat (15) drive_cycle(1'b0, 4'b0110, 1'b1, 2'd1);
    repeat (6)  drive_cycle(1'b0, 4'b0110, 1'b1, 2'd2);
    repeat (10) drive_cycle(1'b0, 4'b0110, 1'b0, 2'd0);

    // Asynchronous reset mid-phase: outputs must clear before any clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_now("async_reset", 11'b00000000_11_0);
    model_reset();
    exp_q.push_back(model_outputs(m_phase, m_dir));
    drive_cycle(1'b1, 4'b0001, 1'b0, 2'd0);
    repeat (20) drive_cycle(1'b0, 4'b0001, 1'b0, 2'd0);

    r = 4'b0000;
    ev = 1'b0;
    ed = 2'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        ev = ($urandom_range(0, 3) == 0);
        ed = 2'($urandom_range(0, 3));
      end
      drive_cycle(1'b0, r, ev, ed);
    end

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
